// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg
//  Shared types and constants for the Hack memory map: data word and
//  word-address types, the screen and keyboard locations, and the state
//  encoding used by the screen scanner.
//  Ports: none (package).
package hack_mem_pkg;

    typedef logic [15:0] word_t;
    typedef logic [14:0] addr_t;

    localparam addr_t SCREEN_BASE   = 15'h4000;
    localparam int    SCREEN_WORDS  = 8192;
    localparam addr_t KBD_ADDR      = 15'h6000;
    localparam int    WORDS_PER_ROW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } scan_state_t;

    // Word address of (row, word) inside the screen region. The 8-bit row
    // and 5-bit word concatenate to a 13-bit offset, so the result can never
    // leave 0x4000..0x5FFF.
    function automatic addr_t screen_addr(input logic [7:0] row, input logic [4:0] word);
        return SCREEN_BASE + addr_t'({row, word});
    endfunction

endpackage

// File: rtl/screen_scanner_pixel_shifter.sv
// pixel_shifter
//  16-bit load/shift register feeding the pixel stream. Bit 0 of the loaded
//  word is presented first; each shift moves the next bit into position and
//  advances the bit index. Load has priority over shift and resets the index.
//  Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, load_data parallel load of a new 16-pixel word
//   shift           advance to the next pixel of the current word
//   pix             current pixel (bit at index bit_idx of the loaded word)
//   bit_idx         index of the current pixel within the word (0..15)
//   last            current pixel is bit 15
module pixel_shifter
    import hack_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  word_t      load_data,
    input  logic       shift,
    output logic       pix,
    output logic [3:0] bit_idx,
    output logic       last
);

    word_t      data_reg;
    word_t      data_next;
    logic [3:0] idx_reg;
    logic [3:0] idx_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            if (gi == 15) begin : g_top
                assign data_next[gi] = load  ? load_data[gi] :
                                       shift ? 1'b0 : data_reg[gi];
            end else begin : g_low
                assign data_next[gi] = load  ? load_data[gi] :
                                       shift ? data_reg[gi+1] : data_reg[gi];
            end
        end
    endgenerate

    assign idx_next = load  ? 4'd0 :
                      shift ? idx_reg + 4'd1 : idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            idx_reg  <= '0;
        end else begin
            data_reg <= data_next;
            idx_reg  <= idx_next;
        end
    end

    assign pix     = data_reg[0];
    assign bit_idx = idx_reg;
    assign last    = (idx_reg == 4'd15);

endmodule

// File: rtl/screen_scanner.sv
// screen_scanner
//  Read-side master for the screen region. Sweeps the bitmap in raster order
//  (row 0 word 0 first, bit 0 of each word leftmost) and emits a 1-bit pixel
//  stream under a valid/ready handshake. One word is prefetched while the
//  current word streams, so the stream is gapless when the sink never stalls.
//  Optional feature (macro SCREEN_SCANNER_CONTINUOUS_EN): with start held high
//  the scanner wraps from the last pixel straight into the next frame.
//  Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level request, sampled while idle
//   mem_rd, mem_addr  read strobe and word address (data returns next cycle)
//   mem_data          read data, valid the cycle after mem_rd
//   pix, pix_valid    pixel (1 = black) and its valid flag
//   pix_ready         sink ready; a pixel is consumed on valid & ready
//   pix_sol, pix_sof  current pixel is column 0 / row 0 column 0
//   busy              frame in progress (start accept to last pixel accepted)
//   done              one-cycle pulse after the last pixel of a frame
module screen_scanner
    import hack_mem_pkg::*;
#(
    parameter int ROWS = 256
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_rd,
    output logic [14:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic        pix,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sol,
    output logic        pix_sof,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
    localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_ROW - 1);

    scan_state_t state_reg, state_next;
    logic [7:0]  row_reg, row_next;
    logic [4:0]  word_reg, word_next;
    word_t       prefetch_reg;
    logic        rd_pending_reg;
    logic        done_reg;

    logic        sh_load, sh_shift, sh_pix, sh_last;
    logic [3:0]  sh_idx;
    word_t       sh_load_data;

    logic        hs, last_word, frame_end, prefetch;
    logic        wrap_req, wrap;
    logic [7:0]  nxt_row;
    logic [4:0]  nxt_word;

    pixel_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (sh_shift),
        .pix       (sh_pix),
        .bit_idx   (sh_idx),
        .last      (sh_last)
    );

    assign hs        = (state_reg == ST_STREAM) && pix_ready;
    assign last_word = (row_reg == LAST_ROW) && (word_reg == LAST_WORD);
    assign frame_end = hs && sh_last && last_word;

    // Location of the word after the one in the shifter; after the final
    // word of the frame this is row 0 word 0 again.
    assign nxt_word = (word_reg == LAST_WORD) ? 5'd0 : word_reg + 5'd1;
    assign nxt_row  = (word_reg != LAST_WORD) ? row_reg :
                      (row_reg == LAST_ROW)   ? 8'd0 : row_reg + 8'd1;

    // The read of the following word goes out on the handshake of bit 0, so
    // at most one read is ever in flight and it lands long before bit 15.
    // On the last word of a frame it only goes out when wrapping is wanted.
    assign prefetch = hs && (sh_idx == 4'd0) && (!last_word || wrap_req);

`ifdef SCREEN_SCANNER_CONTINUOUS_EN
    // Set once the wrap-around read of word 0 has been issued; the frame only
    // wraps if that data is on its way and start is still requested.
    logic armed_reg;

    assign wrap_req = start;
    assign wrap     = armed_reg && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg <= 1'b0;
        end else if (state_reg != ST_STREAM || frame_end) begin
            armed_reg <= 1'b0;
        end else if (prefetch && last_word) begin
            armed_reg <= 1'b1;
        end
    end
`else
    assign wrap_req = 1'b0;
    assign wrap     = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        word_next    = word_reg;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        pix          = 1'b0;
        pix_valid    = 1'b0;
        pix_sol      = 1'b0;
        pix_sof      = 1'b0;
        busy         = 1'b0;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_data = prefetch_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_PRIME;
                    row_next   = 8'd0;
                    word_next  = 5'd0;
                end
            end
            ST_PRIME: begin
                busy       = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = SCREEN_BASE;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy         = 1'b1;
                sh_load      = 1'b1;
                sh_load_data = mem_data;
                state_next   = ST_STREAM;
            end
            ST_STREAM: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                pix       = sh_pix;
                pix_sol   = (word_reg == 5'd0) && (sh_idx == 4'd0);
                pix_sof   = pix_sol && (row_reg == 8'd0);
                if (prefetch) begin
                    mem_rd   = 1'b1;
                    mem_addr = screen_addr(nxt_row, nxt_word);
                end
                if (hs) begin
                    if (sh_last) begin
                        row_next  = nxt_row;
                        word_next = nxt_word;
                        if (last_word && !wrap) begin
                            state_next = ST_DONE;
                        end else begin
                            sh_load = 1'b1;
                        end
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            row_reg        <= '0;
            word_reg       <= '0;
            prefetch_reg   <= '0;
            rd_pending_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            word_reg       <= word_next;
            rd_pending_reg <= mem_rd && (state_reg == ST_STREAM);
            done_reg       <= frame_end;
            if (rd_pending_reg) begin
                prefetch_reg <= mem_data;
            end
        end
    end

    assign done = done_reg;

endmodule

// File: tb/tb_screen_scanner.sv
// tb_screen_scanner
//  Drives screen_scanner (reduced to 4 rows to keep frames short) against a
//  behavioural memory. The expected pixel stream is derived from the image:
//  accepted pixel n shows bit (n mod 16) of word (n / 16), column 0 marks
//  every 512th pixel, and reads must walk the region in order.
module tb_screen_scanner;
    import hack_mem_pkg::*;

    localparam int ROWS        = 4;
    localparam int FRAME_WORDS = ROWS * 32;
    localparam int FRAME_PIX   = FRAME_WORDS * 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        pix, pix_valid, pix_sol, pix_sof, busy, done;
    logic        pix_ready = 1'b0;

    screen_scanner #(.ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .pix       (pix),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sol   (pix_sol),
        .pix_sof   (pix_sof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[13'(mem_addr - 15'h4000)];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model / observation state for the current run
    bit          chk_en = 0;
    bit          gapless = 0;
    int          frames_exp = 1;
    int          total_exp = FRAME_PIX;
    int          acc_cnt, rd_cnt, done_cnt, cyc_cnt, first_rd, first_valid, sol_cnt;
    bit          last_hs_prev, prev_stall, sol_at_512;
    logic [31:0] cap_vec;
    logic [14:0] rd_log [0:255];

    always @(negedge clk) begin : cmp
        int k;
        logic [15:0] w;
        if (chk_en) begin
            cyc_cnt++;
            if (mem_rd) begin
                chk("rd_addr", 32'(mem_addr), 32'(15'h4000 + 15'(rd_cnt % FRAME_WORDS)));
                chk("rd_ahead", 32'(rd_cnt <= acc_cnt / 16 + 1), 32'd1);
                if (rd_cnt < 256) rd_log[rd_cnt] = mem_addr;
                if (first_rd < 0) first_rd = cyc_cnt;
                rd_cnt++;
            end
            if (prev_stall) chk("no_retract", 32'(pix_valid), 32'd1);
            if (gapless && acc_cnt > 0 && acc_cnt < total_exp)
                chk("gapless", 32'(pix_valid), 32'd1);
            chk("done", 32'(done), 32'(last_hs_prev));
            if (done) begin
                chk("busy_at_done", 32'(busy), 32'(done_cnt < frames_exp - 1));
                done_cnt++;
            end
            last_hs_prev = 1'b0;
            if (acc_cnt >= total_exp) begin
                chk("extra_pix", 32'(pix_valid), 32'd0);
            end else if (pix_valid) begin
                k = acc_cnt % FRAME_PIX;
                w = mem[k / 16];
                chk("pix", 32'(pix), 32'(w[k % 16]));
                chk("sol", 32'(pix_sol), 32'(k % 512 == 0));
                chk("sof", 32'(pix_sof), 32'(k == 0));
                chk("busy", 32'(busy), 32'd1);
                if (first_valid < 0) first_valid = cyc_cnt;
                if (pix_ready) begin
                    if (acc_cnt < 32) cap_vec[acc_cnt] = pix;
                    if (pix_sol) sol_cnt++;
                    if (k == 512 && pix_sol) sol_at_512 = 1'b1;
                    acc_cnt++;
                    last_hs_prev = (k == FRAME_PIX - 1);
                end
            end
            prev_stall = pix_valid && !pix_ready;
        end
    end

    // Runs one request. rnd: random sink stalls; hold: keep start high until
    // the first done; abort_at > 0: return early once that many pixels are taken.
    task automatic run_frame(input bit rnd, input bit hold, input int abort_at);
        int  budget;
        bit  dropped;
        acc_cnt = 0; rd_cnt = 0; done_cnt = 0; cyc_cnt = 0; sol_cnt = 0;
        first_rd = -1; first_valid = -1;
        last_hs_prev = 0; prev_stall = 0; sol_at_512 = 0; cap_vec = '0;
`ifdef SCREEN_SCANNER_CONTINUOUS_EN
        frames_exp = hold ? 2 : 1;
`else
        frames_exp = 1;
`endif
        total_exp = frames_exp * FRAME_PIX;
        gapless   = !rnd;
        chk_en    = 1;
        start     = 1'b1;
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        dropped   = 0;
        budget    = 0;
        while (done_cnt < frames_exp && budget < 20000) begin
            @(posedge clk); #1;
            budget++;
            if (abort_at > 0 && acc_cnt >= abort_at) return;
            if (!dropped && (!hold || done_cnt > 0)) begin
                start   = 1'b0;
                dropped = 1;
            end
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
        end
        if (budget >= 20000) chk("timeout", 32'(done_cnt), 32'(frames_exp));
        pix_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("pix_count", 32'(acc_cnt), 32'(total_exp));
        chk("rd_count", 32'(rd_cnt), 32'(frames_exp * FRAME_WORDS));
        chk("done_count", 32'(done_cnt), 32'(frames_exp));
        chk("busy_end", 32'(busy), 32'd0);
        chk("first_rd_cycle", 32'(first_rd), 32'd2);
        chk("first_valid_cycle", 32'(first_valid), 32'd4);
        chk("rd_first_addr", 32'(rd_log[0]), 32'h4000);
        chk_en = 0;
        $display("run rnd=%0d hold=%0d: pixels=%0d reads=%0d dones=%0d", rnd, hold, acc_cnt, rd_cnt, done_cnt);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix"}, 32'(pix), 32'd0);
        chk({tag, "_sol_sof"}, 32'({pix_sol, pix_sof}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'((i * 40503) ^ (i << 5) ^ 16'h3C5A);
        mem[0] = 16'h0005;
        mem[1] = 16'hFFFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort in row 3, then verify outputs clear at once and no done appears
        run_frame(0, 0, 3 * 512 + 40);
        chk_en = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        chk_idle_outputs("abort");
        $display("abort after %0d pixels", acc_cnt);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full frame with the sink always ready
        run_frame(0, 0, 0);
        chk("first32_pixels", cap_vec, 32'hFFFF0005);
        chk("sol_count", 32'(sol_cnt), 32'(ROWS));
        chk("sol_at_512", 32'(sol_at_512), 32'd1);
        chk("addr_row0_end", 32'(rd_log[31]), 32'h401F);
        chk("addr_row1_start", 32'(rd_log[32]), 32'h4020);
        chk("addr_last", 32'(rd_log[FRAME_WORDS - 1]), 32'h407F);

        // Full frame with random stalls
        run_frame(1, 0, 0);
        chk("rand_first32", cap_vec, 32'hFFFF0005);
        chk("rand_sol_count", 32'(sol_cnt), 32'(ROWS));

        // start held across the frame end
        run_frame(0, 1, 0);
`ifdef SCREEN_SCANNER_CONTINUOUS_EN
        chk("cont_sol_count", 32'(sol_cnt), 32'(2 * ROWS));
        chk("cont_wrap_addr", 32'(rd_log[FRAME_WORDS]), 32'h4000);
`else
        chk("hold_sol_count", 32'(sol_cnt), 32'(ROWS));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
